// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants for the transmitter and future receiver
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: bit-period counter that pulses tick_out on the last cycle of each bit
module baud_tick_gen #(
  parameter int DIVISOR = 868
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic en_in,
  output logic tick_out
);
  localparam int W = $clog2(DIVISOR);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick_out = en_in && cnt_q == W'(DIVISOR - 1);
  always_comb cnt_d = (!en_in || tick_out) ? '0 : cnt_q + W'(1);
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 LSB-first transmitter with a one-byte holding register for gapless frames
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_out,
  output logic       busy_out
);
  localparam int DIVISOR = CLK_HZ / BAUD;
  tx_state_t state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d, hold_q, hold_d;
  logic [2:0] idx_q, idx_d;
  logic full_q, full_d, tx_q, tx_d, tick, load, accept;
  baud_tick_gen #(.DIVISOR(DIVISOR)) u_tick (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .en_in   (state_q != IDLE),
    .tick_out(tick)
  );
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      IDLE:  if (full_q) begin
        load    = 1'b1;
        state_d = START;
      end
      START: if (tick) begin
        state_d = DATA;
        idx_d   = '0;
      end
      DATA:  if (tick) begin
        shift_d = shift_q >> 1;
        idx_d   = idx_q + 3'd1;
        if (idx_q == 3'(UART_DATA_BITS - 1)) state_d = STOP;
      end
      STOP:  if (tick) begin
        load    = full_q;
        state_d = full_q ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) shift_d = hold_q;
  end
  assign accept = valid_in && !full_q;
  assign full_d = accept || (full_q && !load);
  assign hold_d = accept ? data_in : hold_q;
  // line level follows the state one cycle late so tx_out is a clean flop
  assign tx_d = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state_q <= IDLE;
      shift_q <= '0;
      hold_q  <= '0;
      idx_q   <= '0;
      full_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      full_q  <= full_d;
      tx_q    <= tx_d;
    end
  assign ready_out = !full_q;
  assign busy_out  = state_q != IDLE;
  assign tx_out    = tx_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: frame-schedule reference model plus vector table and directed corner sequences
module tb_uart_tx;
  logic clk = 1'b0, rst_in = 1'b1, valid_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic tx_out, ready_out, busy_out;
  always #5 clk = ~clk;
  uart_tx #(.CLK_HZ(800), .BAUD(100)) dut (
    .clk_in   (clk),
    .rst_in   (rst_in),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .tx_out   (tx_out),
    .busy_out (busy_out)
  );
  typedef struct {int len; logic tx; logic busy; logic ready;} seg_t;
  seg_t tbl [14];
  int checks = 0, errors = 0;
  int n = 0, last_end = 0;
  bit m_full = 1'b0, gate = 1'b0;
  logic [7:0] m_byte = 8'h00;
  int fs[$];
  logic [7:0] fb[$], src[$], expq[$];
  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %b want %b", name, n, act, exp);
    end
  endtask
  task automatic chkv(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d want %0d", name, n, act, exp);
    end
  endtask
  // line level after edge n reflects whichever frame covered cycle n-1
  function automatic logic exp_tx();
    for (int i = fs.size() - 1; i >= 0; i--) begin
      int o, b;
      o = n - 1 - fs[i];
      b = o / 8;
      if (o >= 0 && o < 80) return b == 0 ? 1'b0 : b == 9 ? 1'b1 : fb[i][b-1];
    end
    return 1'b1;
  endfunction
  task automatic drive();
    valid_in = src.size() > 0 && (!gate || $urandom_range(3) != 0);
    data_in  = src.size() > 0 ? src[0] : 8'($urandom);
  endtask
  task automatic step();
    bit hs, pre, ld, acc;
    hs = valid_in && ready_out;
    @(posedge clk);
    n++;
    if (rst_in) begin
      m_full = 1'b0;
      last_end = n;
      fs.delete();
      fb.delete();
    end else begin
      pre = m_full;
      ld  = pre && n >= last_end;
      acc = valid_in && !pre;
      if (ld) begin
        fs.push_back(n);
        fb.push_back(m_byte);
        last_end = n + 80;
      end
      if (acc) m_byte = data_in;
      m_full = acc || (pre && !ld);
      if (hs) void'(src.pop_front());
    end
    @(negedge clk);
    chk("tx", tx_out, exp_tx());
    chk("busy", busy_out, n < last_end);
    chk("ready", ready_out, !m_full);
    drive();
  endtask
  task automatic rx_byte(output logic [7:0] b, output int s);
    int t;
    t = 0;
    b = '0;
    s = 0;
    while (tx_out !== 1'b0 && t < 2000) begin
      step();
      t++;
    end
    if (tx_out !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL rx_timeout at edge %0d: got no start bit want one within 2000 cycles", n);
      return;
    end
    s = n;
    repeat (4) step();
    for (int i = 0; i < 8; i++) begin
      repeat (8) step();
      b[i] = tx_out;
    end
    repeat (8) step();
    chk("rx_stop", tx_out, 1'b1);
  endtask
  initial begin
    logic [7:0] a5, b, r;
    int s0, s1;
    a5 = 8'hA5;
    tbl[0] = '{1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{8, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) tbl[3+i] = '{8, a5[i], 1'b1, 1'b1};
    tbl[11] = '{7, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{20, 1'b1, 1'b0, 1'b1};
    drive();
    repeat (3) step();
    chk("reset_tx", tx_out, 1'b1);
    chk("reset_ready", ready_out, 1'b1);
    chk("reset_busy", busy_out, 1'b0);
    rst_in = 1'b0;
    repeat (2) step();
    src.push_back(8'hA5);
    drive();
    foreach (tbl[i]) repeat (tbl[i].len) begin
      step();
      chk("vec_tx", tx_out, tbl[i].tx);
      chk("vec_busy", busy_out, tbl[i].busy);
      chk("vec_ready", ready_out, tbl[i].ready);
    end
    src.push_back(8'h00);
    src.push_back(8'hFF);
    drive();
    rx_byte(b, s0);
    chkv("b2b_first", b, 8'h00);
    rx_byte(b, s1);
    chkv("b2b_second", b, 8'hFF);
    chkv("b2b_gap", s1 - s0, 80);
    repeat (20) step();
    src.push_back(8'h11);
    src.push_back(8'h22);
    src.push_back(8'h33);
    drive();
    rx_byte(b, s0);
    chkv("bp_first", b, 8'h11);
    chkv("bp_pending", src.size(), 1);
    rx_byte(b, s1);
    chkv("bp_second", b, 8'h22);
    rx_byte(b, s1);
    chkv("bp_third", b, 8'h33);
    repeat (20) step();
    src.push_back(8'h3C);
    src.push_back(8'h5A);
    drive();
    step();
    chk("sim_ready_full", ready_out, 1'b0);
    step();
    chkv("sim_not_yet", src.size(), 1);
    step();
    chkv("sim_captured", src.size(), 0);
    rx_byte(b, s0);
    chkv("sim_first", b, 8'h3C);
    rx_byte(b, s1);
    chkv("sim_second", b, 8'h5A);
    chkv("sim_gap", s1 - s0, 80);
    repeat (20) step();
    src.push_back(8'hC3);
    drive();
    step();
    repeat (45) step();
    chk("rst_pre_tx", tx_out, 1'b0);
    chk("rst_pre_busy", busy_out, 1'b1);
    #2 rst_in = 1'b1;
    #1;
    chk("rst_async_tx", tx_out, 1'b1);
    chk("rst_async_ready", ready_out, 1'b1);
    chk("rst_async_busy", busy_out, 1'b0);
    step();
    rst_in = 1'b0;
    step();
    src.push_back(8'h96);
    drive();
    rx_byte(b, s0);
    chkv("rst_after", b, 8'h96);
    repeat (10) step();
    repeat (1000) begin
      step();
      chk("idle_tx", tx_out, 1'b1);
      chk("idle_busy", busy_out, 1'b0);
    end
    gate = 1'b1;
    for (int i = 0; i < 25; i++) begin
      r = 8'($urandom);
      src.push_back(r);
      expq.push_back(r);
    end
    drive();
    foreach (expq[i]) begin
      rx_byte(b, s0);
      chkv("rand_byte", b, expq[i]);
    end
    gate = 1'b0;
    repeat (100) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
